ifetch_ctrl: RTL and testbench
==============================

// Module: ifetch_ctrl
// PURPOSE
//  Owns the architectural PC and fetches instructions from instruction memory; the consumer of the next-PC value.
//  Presents PC, pc4 and the fetched instruction to decode/execute and the next-PC logic.
//  Commits the core's computed npc when the core retires the current instruction.
//  Sits between the instruction-memory port and the core datapath.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded by reset; first fetch address
//  ADDR_W     32             PC / memory address width
// PORTS
//  clk          in   1       core clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  npc          in   ADDR_W  next PC from next-PC logic, sampled on inst_step
//  inst_step    in   1       core retires current instruction; meaningful only while inst_valid=1
//  PC           out  ADDR_W  address of the instruction in flight / held
//  pc4          out  ADDR_W  PC + 4, combinational from PC
//  inst         out  32      fetched instruction, stable while inst_valid=1
//  inst_valid   out  1       inst holds the word for PC
//  imem_req     out  1       fetch request, held until imem_gnt
//  imem_addr    out  ADDR_W  fetch address (= PC)
//  imem_gnt     in   1       memory accepts request this cycle
//  imem_rvalid  in   1       read data valid; earliest one cycle after gnt
//  imem_rdata   in   32      read data
//  fetch_fault  out  1       misaligned-target fault (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync release): PC=RESET_PC, inst=0, inst_valid=0, imem_req=0, fetch_fault=0, state=S_IDLE.
//  FSM: S_IDLE -> S_REQ unconditionally on the first clock after reset release.
//   S_REQ:  imem_req=1, imem_addr=PC; on imem_gnt -> S_WAIT.
//   S_WAIT: imem_req=0; on imem_rvalid: inst<=imem_rdata, inst_valid<=1 -> S_HOLD.
//   S_HOLD: inst/PC stable; on inst_step: PC<=npc, inst_valid<=0 -> S_REQ.
//   S_FAULT (macro only): terminal; imem_req=0, inst_valid=0, fetch_fault=1 until reset.
//  Latency: zero-wait memory (gnt in S_REQ, rvalid next cycle) gives inst_valid 2 cycles after entering S_REQ.
//   Issue rate is one instruction per 3 cycles including the step cycle.
//  imem_addr/imem_req are stable while imem_req=1 and gnt=0; no request is withdrawn.
//  imem_rvalid outside S_WAIT is ignored; inst_step outside S_HOLD is ignored.
//  Only one outstanding request at any time.
//  pc4 = PC + 4, modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0. npc is taken verbatim (no wrap check).
//  npc == PC on step (self-loop) re-fetches the same address; this is not optimised away.
//  Reset mid-fetch (S_REQ/S_WAIT): the request is abandoned.
//   A late imem_rvalid after reset release is ignored because state is no longer S_WAIT.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined:
//   On inst_step with npc[1:0]!=2'b00: PC<=npc, go to S_FAULT, no request issued.
//   Applies also to RESET_PC[1:0]!=0, which enters S_FAULT from S_IDLE.
//  Not defined:
//   PC loads {npc[ADDR_W-1:2],2'b00}; fetch_fault tied 0; S_FAULT unreachable.
// STRUCTURE
//  Shared package ifetch_pkg:
//   state encoding S_IDLE/S_REQ/S_WAIT/S_HOLD/S_FAULT (3-bit)
//   INST_W=32, PC_STEP=4
//   NOP constant 32'h0000_0013 (bench reference only; inst resets to 0)
//  One natural sub-module: ifetch_pc_reg, the PC flop with async reset to RESET_PC.
//   Provides load enable, alignment masking and the pc4 adder.
//  FSM and instruction register stay in ifetch_ctrl.
// TESTING
//  Reset release, gnt=1, 1-cycle rvalid, rdata=32'h0000_0093
//   -> imem_addr=0 on cycle 1; inst_valid=1 on cycle 3; pc4=4.
//  In S_HOLD, step with npc=32'h0000_0100
//   -> next cycle imem_req=1, imem_addr=32'h100, inst_valid=0.
//  Hold gnt=0 for 5 cycles -> imem_req and imem_addr constant throughout; gnt on cycle 6 -> S_WAIT.
//  Assert rst in S_WAIT, release, then pulse rvalid with rdata=32'hDEAD_BEEF
//   -> inst_valid stays 0; fresh request to RESET_PC.
//  PC=32'hFFFF_FFFC -> pc4=0; step npc=pc4 -> next fetch addr 0.
//  Step npc=32'h0000_0102
//   -> with FETCH_MISALIGN_TRAP_EN: fetch_fault=1, imem_req=0 forever.
//   -> without it: fetch at 32'h100.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    // Canonical NOP; inst itself resets to zero, not to this.
    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Instruction-memory request/response port, one outstanding request at a time.
interface ifetch_ctrl_if import ifetch_pkg::*; #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_pc_reg.sv
// Architectural PC register with load enable, target alignment and pc4 adder.
// With FETCH_MISALIGN_TRAP_EN the target is loaded verbatim so the fault path can see it.
module ifetch_pc_reg import ifetch_pkg::*; #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] npc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] load_val;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign load_val = npc;
`else
    // Drop the low two bits so the fetch address is always word aligned.
    assign load_val = npc & ~ADDR_W'(3);
`endif

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc  = pc_q;
    assign pc4 = pc_q + ADDR_W'(PC_STEP);
endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: owns the PC, issues one imem request per instruction, holds it until retired.
// Optional FETCH_MISALIGN_TRAP_EN adds a terminal fault state for misaligned targets.
module ifetch_ctrl import ifetch_pkg::*; #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   npc,
    input  logic                inst_step,
    output logic [ADDR_W-1:0]   PC,
    output logic [ADDR_W-1:0]   pc4,
    output logic [INST_W-1:0]   inst,
    output logic                inst_valid,
    output logic                fetch_fault,
    ifetch_ctrl_if.master       imem
);
    state_t            state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic              pc_load;

    // Only a retirement in S_HOLD may move the PC; steps elsewhere are ignored.
    assign pc_load = (state_q == S_HOLD) && inst_step;

    ifetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .npc  (npc),
        .pc   (PC),
        .pc4  (pc4)
    );

    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        case (state_q)
            S_IDLE: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                state_d = (RESET_PC[1:0] != 2'b00) ? S_FAULT : S_REQ;
`else
                state_d = S_REQ;
`endif
            end
            S_REQ: begin
                if (imem.imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    inst_d       = imem.imem_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_step) begin
                    inst_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_d = (npc[1:0] != 2'b00) ? S_FAULT : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_FAULT: begin
                inst_valid_d = 1'b0;
                state_d      = S_FAULT;
            end
            default: begin
                inst_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign imem.imem_req  = (state_q == S_REQ);
    assign imem.imem_addr = PC;
    assign inst           = inst_q;
    assign inst_valid     = inst_valid_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = (state_q == S_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: bench acts as instruction memory, scoreboard pairs grants with returned words.
module tb_ifetch_ctrl;
    import ifetch_pkg::*;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic        inst_step;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        fetch_fault_o;

    ifetch_ctrl_if #(.ADDR_W(ADDR_W)) imem ();

    ifetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .inst_step   (inst_step),
        .PC          (pc_o),
        .pc4         (pc4_o),
        .inst        (inst_o),
        .inst_valid  (inst_valid_o),
        .fetch_fault (fetch_fault_o),
        .imem        (imem.master)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_t;

    fetch_t sb_q[$];
    int     n_assert = 0;
    int     n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a request, then serve it; optional gnt stall with stray rvalid/step pulses.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int gnt_delay);
        fetch_t e;
        for (int i = 0; i < 20 && imem.imem_req !== 1'b1; i++) tick();
        chk("req_seen", {31'd0, imem.imem_req}, 32'd1);
        for (int k = 0; k < gnt_delay; k++) begin
            chk("stall_req", {31'd0, imem.imem_req}, 32'd1);
            chk("stall_addr", imem.imem_addr, addr);
            chk("stall_valid", {31'd0, inst_valid_o}, 32'd0);
            imem.imem_rvalid = (k == 0);
            imem.imem_rdata  = 32'hBAD0_BAD0;
            inst_step        = (k == 0);
            npc              = 32'h0000_0500;
            tick();
            imem.imem_rvalid = 1'b0;
            inst_step        = 1'b0;
        end
        chk("req_addr", imem.imem_addr, addr);
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        chk("wait_req", {31'd0, imem.imem_req}, 32'd0);
        chk("wait_valid", {31'd0, inst_valid_o}, 32'd0);
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = data;
        e.addr = addr;
        e.data = data;
        sb_q.push_back(e);
        tick();
        imem.imem_rvalid = 1'b0;
        chk("hold_valid", {31'd0, inst_valid_o}, 32'd1);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("sb_inst", inst_o, e.data);
            chk("sb_pc", pc_o, e.addr);
        end
        $display("fetch addr=%h inst=%h valid=%0b", pc_o, inst_o, inst_valid_o);
    endtask

    task automatic step(input logic [31:0] nv, input logic [31:0] exp_addr);
        chk("step_pre_valid", {31'd0, inst_valid_o}, 32'd1);
        npc       = nv;
        inst_step = 1'b1;
        tick();
        inst_step = 1'b0;
        chk("step_req", {31'd0, imem.imem_req}, 32'd1);
        chk("step_addr", imem.imem_addr, exp_addr);
        chk("step_valid", {31'd0, inst_valid_o}, 32'd0);
        $display("step npc=%h -> req=%0b addr=%h", nv, imem.imem_req, imem.imem_addr);
    endtask

    initial begin
        rst              = 1'b1;
        npc              = '0;
        inst_step        = 1'b0;
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        tick();
        tick();
        chk("rst_pc", pc_o, RESET_PC);
        chk("rst_pc4", pc4_o, 32'h0000_0004);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault_o}, 32'd0);

        // Zero-wait fetch: request on cycle 1, inst_valid on cycle 3.
        rst = 1'b0;
        chk("idle_req", {31'd0, imem.imem_req}, 32'd0);
        tick();
        chk("c1_req", {31'd0, imem.imem_req}, 32'd1);
        fetch(32'h0000_0000, 32'h0000_0093, 0);
        chk("pc4_first", pc4_o, 32'h0000_0004);

        step(32'h0000_0100, 32'h0000_0100);
        fetch(32'h0000_0100, NOP, 5);

        // Reset while in S_WAIT; late rvalid after release must be ignored.
        step(32'h0000_0200, 32'h0000_0200);
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        chk("pre_rst_wait", {31'd0, imem.imem_req}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem.imem_rvalid = 1'b0;
        chk("late_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("late_inst", inst_o, 32'd0);
        chk("refetch_req", {31'd0, imem.imem_req}, 32'd1);
        chk("refetch_addr", imem.imem_addr, RESET_PC);
        fetch(RESET_PC, 32'h0010_0113, 0);

        // Top of address space: pc4 wraps to zero.
        step(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0020_0193, 1);
        chk("pc4_wrap", pc4_o, 32'h0000_0000);
        step(32'h0000_0000, 32'h0000_0000);
        fetch(32'h0000_0000, 32'h0030_0213, 0);

        // Self-loop re-fetches the same address.
        step(32'h0000_0000, 32'h0000_0000);
        fetch(32'h0000_0000, 32'h0040_0293, 0);

`ifdef FETCH_MISALIGN_TRAP_EN
        npc       = 32'h0000_0102;
        inst_step = 1'b1;
        tick();
        inst_step = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("fault_flag", {31'd0, fetch_fault_o}, 32'd1);
            chk("fault_req", {31'd0, imem.imem_req}, 32'd0);
            chk("fault_valid", {31'd0, inst_valid_o}, 32'd0);
            chk("fault_pc", pc_o, 32'h0000_0102);
            imem.imem_gnt = 1'b1;
            tick();
        end
        imem.imem_gnt = 1'b0;
        $display("misaligned step -> fault=%0b req=%0b", fetch_fault_o, imem.imem_req);
`else
        step(32'h0000_0102, 32'h0000_0100);
        chk("align_pc", pc_o, 32'h0000_0100);
        chk("align_fault", {31'd0, fetch_fault_o}, 32'd0);
        fetch(32'h0000_0100, 32'h0050_0313, 0);
`endif

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
